// File: rtl/coa_share_ctrl_pkg.sv
// Shared definitions for the COA sharing controller: FSM state encoding,
// default widths and the timeout-counter width helper.
package coa_share_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W_IN    = 5;
  localparam int DEF_W_OUT   = 10;
  localparam int DEF_TIMEOUT = 64;

  // Bits needed to count WAIT cycles 0..timeout-1.
  function automatic int wcnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/coa_share_ctrl_if.sv
// Bundle of requester-side and COA-side signals of the sharing controller.
// The controller uses the slave modport; requesters plus the COA unit sit on
// the master side.
interface coa_share_ctrl_if
  import coa_share_ctrl_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W_IN  = DEF_W_IN,
  parameter int W_OUT = DEF_W_OUT
);

  logic [N_REQ-1:0]      req;
  logic [N_REQ*W_IN-1:0] req_a;
  logic [N_REQ*W_IN-1:0] req_b;
  logic [N_REQ*W_IN-1:0] req_c;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      rsp_valid;
  logic                  rsp_err;
  logic [W_OUT-1:0]      rsp_d;
  logic                  busy;
  logic                  coa_valid_in;
  logic [W_IN-1:0]       coa_a;
  logic [W_IN-1:0]       coa_b;
  logic [W_IN-1:0]       coa_c;
  logic                  coa_valid_out;
  logic [W_OUT-1:0]      coa_d;
  logic                  coa_rst_n;

  modport slave (
    input  req, req_a, req_b, req_c, coa_valid_out, coa_d,
    output gnt, rsp_valid, rsp_err, rsp_d, busy,
           coa_valid_in, coa_a, coa_b, coa_c, coa_rst_n
  );

  modport master (
    output req, req_a, req_b, req_c, coa_valid_out, coa_d,
    input  gnt, rsp_valid, rsp_err, rsp_d, busy,
           coa_valid_in, coa_a, coa_b, coa_c, coa_rst_n
  );

endinterface

// File: rtl/coa_share_ctrl_rr_pick.sv
// Round-robin picker: first set request bit at or after rr_ptr, wrapping
// around. Purely combinational; pick_oh is all-zero when nothing is requested.
module coa_share_ctrl_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [PTR_W-1:0] pick_idx
);

  logic found;
  int   cand;

  // Scan requesters cyclically starting at rr_ptr and keep the first hit.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        pick_oh[cand] = 1'b1;
        pick_idx      = PTR_W'(cand);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coa_share_ctrl.sv
// Round-robin controller sharing one COA arithmetic unit between N_REQ
// requesters. Operands are captured at selection, issued once, and the result
// is returned to the owning requester; a watchdog aborts silent transactions
// and pulses the COA reset.
module coa_share_ctrl
  import coa_share_ctrl_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W_IN    = DEF_W_IN,
  parameter int W_OUT   = DEF_W_OUT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  coa_share_ctrl_if.slave bus
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int WCNT_W = wcnt_width(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);

  state_t            state;
  state_t            next_state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic [W_IN-1:0]   cap_a;
  logic [W_IN-1:0]   cap_b;
  logic [W_IN-1:0]   cap_c;
  logic [W_OUT-1:0]  d_lat;
  logic [WCNT_W-1:0] wcnt;
  logic              flush;

  coa_share_ctrl_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req      (bus.req),
    .rr_ptr   (rr_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // State register; reset aborts whatever transaction is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state: one transaction walks IDLE->ISSUE->WAIT->RESP or ->FLUSH.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (|pick_oh) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (bus.coa_valid_out)    next_state = ST_RESP;
        else if (wcnt == WCNT_LAST) next_state = ST_FLUSH;
      end
      ST_RESP:  next_state = ST_IDLE;
      ST_FLUSH: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Capture registers, fairness pointer, watchdog counter and result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      owner  <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
      cap_c  <= '0;
      d_lat  <= '0;
      wcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick_oh) begin
            owner <= pick_idx;
            cap_a <= bus.req_a[int'(pick_idx)*W_IN +: W_IN];
            cap_b <= bus.req_b[int'(pick_idx)*W_IN +: W_IN];
            cap_c <= bus.req_c[int'(pick_idx)*W_IN +: W_IN];
          end
        end
        ST_ISSUE: begin
          wcnt   <= '0;
          rr_ptr <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
        end
        ST_WAIT: begin
          if (bus.coa_valid_out)    d_lat <= bus.coa_d;
          else if (wcnt != WCNT_LAST) wcnt  <= wcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state and the transaction owner.
  always_comb begin
    bus.gnt          = '0;
    bus.rsp_valid    = '0;
    bus.rsp_err      = 1'b0;
    bus.rsp_d        = '0;
    bus.coa_valid_in = 1'b0;
    flush            = 1'b0;
    case (state)
      ST_ISSUE: begin
        bus.gnt[owner]   = 1'b1;
        bus.coa_valid_in = 1'b1;
      end
      ST_RESP: begin
        bus.rsp_valid[owner] = 1'b1;
        bus.rsp_d            = d_lat;
      end
      ST_FLUSH: begin
        bus.rsp_valid[owner] = 1'b1;
        bus.rsp_err          = 1'b1;
        flush                = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.coa_a     = cap_a;
  assign bus.coa_b     = cap_b;
  assign bus.coa_c     = cap_c;
  assign bus.coa_rst_n = ~(rst | flush);

endmodule
